// File: rtl/abp_mc_responder.sv
// ---------------------------------------------------------------------------
// abp_mc_responder
//
// Multi-channel alternating-bit-protocol responder. It sits between the
// Ethernet RX and TX AXI-Stream paths of the ABP endpoint. For each
// received packet the alternating bit is checked against that channel's
// expected bit:
//   - new data  : reply = value + INCREMENT, stored as the channel's last
//                 reply, and the expected bit toggles
//   - duplicate : the stored last reply is sent again, unchanged
//   - malformed : wrong length or bad channel, dropped and counted
//
// Packet layout (input and output):
//   byte 0              : [7] ABP bit, [6:0] channel index
//   bytes 1..VALUE_SIZE : value, MSB first
//   remaining bytes     : padding (ignored on input, 0x00 on output)
//   byte PACKET_SIZE-1  : carries tlast
//
// Ports:
//   aclk, aresetn        clock, asynchronous active-low reset
//   s_axis_*             byte-wide input stream (tvalid/tdata/tlast/tready)
//   m_axis_*             byte-wide output stream (tvalid/tdata/tlast/tready)
//   stat_accepted        saturating count of new packets accepted
//   stat_duplicate       saturating count of duplicates replayed
//   stat_error           saturating count of malformed packets dropped
//   busy                 high whenever the FSM is not in RX_IDLE
// ---------------------------------------------------------------------------
module abp_mc_responder #(
    parameter int VALUE_SIZE   = 4,
    parameter int PACKET_SIZE  = 64,
    parameter int NUM_CHANNELS = 4,
    parameter int INCREMENT    = 1,
    parameter int STAT_WIDTH   = 16
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  s_axis_tvalid,
    input  logic [7:0]            s_axis_tdata,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic                  m_axis_tvalid,
    output logic [7:0]            m_axis_tdata,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic [STAT_WIDTH-1:0] stat_accepted,
    output logic [STAT_WIDTH-1:0] stat_duplicate,
    output logic [STAT_WIDTH-1:0] stat_error,
    output logic                  busy
);

    // state   | meaning
    // --------+-----------------------------------------------------------
    // RX_IDLE | waiting for byte 0 of a packet
    // RX      | receiving bytes 1..PACKET_SIZE-1, shifting in the value
    // DRAIN   | over-long packet: discard bytes up to and including tlast
    // CHECK   | one cycle: validate channel, compare bit, form the reply
    // TX      | sending the reply packet, advancing only on handshake

    localparam int VW = 8 * VALUE_SIZE;
    localparam int CW = $clog2(PACKET_SIZE + 1);
    localparam int IW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    localparam logic [CW-1:0]         LAST_IDX = CW'(PACKET_SIZE - 1);
    localparam logic [CW-1:0]         VAL_LAST = CW'(VALUE_SIZE);
    localparam logic [STAT_WIDTH-1:0] STAT_MAX = '1;

    typedef enum logic [2:0] {
        RX_IDLE = 3'd0,
        RX      = 3'd1,
        DRAIN   = 3'd2,
        CHECK   = 3'd3,
        TX      = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [CW-1:0]  r_cnt;
    logic [6:0]     r_chan;
    logic           r_bit;
    logic [VW-1:0]  r_value;
    logic [VW-1:0]  r_reply;

    logic [NUM_CHANNELS-1:0] r_exp_bit;
    logic [VW-1:0]           r_last_val [NUM_CHANNELS];

    logic                  w_ready;
    logic                  w_in_hs;
    logic                  w_out_hs;
    logic                  w_ch_ok;
    logic [IW-1:0]         w_idx;
    logic                  w_is_new;
    logic [VW-1:0]         w_sum;
    logic                  w_err_inc;
    logic                  w_acc_inc;
    logic                  w_dup_inc;

    // tready is forced low while reset is asserted, even though the state
    // register already sits in RX_IDLE.
    assign s_axis_tready = w_ready & aresetn;
    assign w_in_hs       = s_axis_tvalid & s_axis_tready;
    assign w_out_hs      = m_axis_tvalid & m_axis_tready;
    assign busy          = (r_state != RX_IDLE);

    assign w_ch_ok  = ({1'b0, r_chan} < 8'(NUM_CHANNELS));
    assign w_idx    = IW'(r_chan);
    assign w_is_new = (r_bit == r_exp_bit[w_idx]);
    assign w_sum    = r_value + VW'(INCREMENT);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= RX_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_ready       = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = 8'h00;
        m_axis_tlast  = 1'b0;
        w_err_inc     = 1'b0;
        w_acc_inc     = 1'b0;
        w_dup_inc     = 1'b0;

        case (r_state)
            RX_IDLE: begin
                w_ready = 1'b1;
                if (w_in_hs) begin
                    if (s_axis_tlast) begin
                        w_err_inc = 1'b1;
                    end else begin
                        w_next = RX;
                    end
                end
            end

            RX: begin
                w_ready = 1'b1;
                if (w_in_hs) begin
                    if (r_cnt == LAST_IDX) begin
                        if (s_axis_tlast) begin
                            w_next = CHECK;
                        end else begin
                            w_err_inc = 1'b1;
                            w_next    = DRAIN;
                        end
                    end else if (s_axis_tlast) begin
                        w_err_inc = 1'b1;
                        w_next    = RX_IDLE;
                    end
                end
            end

            DRAIN: begin
                w_ready = 1'b1;
                if (w_in_hs && s_axis_tlast) begin
                    w_next = RX_IDLE;
                end
            end

            CHECK: begin
                if (!w_ch_ok) begin
                    w_err_inc = 1'b1;
                    w_next    = RX_IDLE;
                end else begin
                    w_acc_inc = w_is_new;
                    w_dup_inc = ~w_is_new;
                    w_next    = TX;
                end
            end

            TX: begin
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = (r_cnt == LAST_IDX);
                if (r_cnt == '0) begin
                    m_axis_tdata = {r_bit, r_chan};
                end else if (r_cnt <= VAL_LAST) begin
                    // r_reply is shifted left on each value byte sent, so the
                    // current byte is always in the top lane.
                    m_axis_tdata = r_reply[VW-1 -: 8];
                end
                if (w_out_hs && m_axis_tlast) begin
                    w_next = RX_IDLE;
                end
            end

            default: begin
                w_next = RX_IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_cnt     <= '0;
            r_chan    <= '0;
            r_bit     <= 1'b0;
            r_value   <= '0;
            r_reply   <= '0;
            r_exp_bit <= '0;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                r_last_val[i] <= '0;
            end
        end else begin
            case (r_state)
                RX_IDLE: begin
                    if (w_in_hs && !s_axis_tlast) begin
                        r_chan <= s_axis_tdata[6:0];
                        r_bit  <= s_axis_tdata[7];
                        r_cnt  <= CW'(1);
                    end
                end

                RX: begin
                    if (w_in_hs) begin
                        r_cnt <= r_cnt + CW'(1);
                        if (r_cnt <= VAL_LAST) begin
                            r_value <= (r_value << 8) | VW'(s_axis_tdata);
                        end
                    end
                end

                CHECK: begin
                    r_cnt <= '0;
                    if (w_ch_ok) begin
                        if (w_is_new) begin
                            r_reply           <= w_sum;
                            r_last_val[w_idx] <= w_sum;
                            r_exp_bit[w_idx]  <= ~r_exp_bit[w_idx];
                        end else begin
                            r_reply <= r_last_val[w_idx];
                        end
                    end
                end

                TX: begin
                    if (w_out_hs) begin
                        r_cnt <= r_cnt + CW'(1);
                        if ((r_cnt != '0) && (r_cnt <= VAL_LAST)) begin
                            r_reply <= r_reply << 8;
                        end
                    end
                end

                default: begin
                end
            endcase
        end
    end

    // Saturating statistics: each counter sticks at all-ones.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            stat_accepted  <= '0;
            stat_duplicate <= '0;
            stat_error     <= '0;
        end else begin
            if (w_acc_inc && (stat_accepted != STAT_MAX)) begin
                stat_accepted <= stat_accepted + 1'b1;
            end
            if (w_dup_inc && (stat_duplicate != STAT_MAX)) begin
                stat_duplicate <= stat_duplicate + 1'b1;
            end
            if (w_err_inc && (stat_error != STAT_MAX)) begin
                stat_error <= stat_error + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_abp_mc_responder.sv
module tb_abp_mc_responder;

    localparam int PS = 64;
    localparam int VS = 4;
    localparam int NC = 4;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        s_axis_tvalid = 1'b0;
    logic [7:0]  s_axis_tdata = 8'h00;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_tready;
    logic        m_axis_tvalid;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tlast;
    logic        m_axis_tready = 1'b1;
    logic [15:0] stat_accepted;
    logic [15:0] stat_duplicate;
    logic [15:0] stat_error;
    logic        busy;

    abp_mc_responder dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tlast   (s_axis_tlast),
        .s_axis_tready  (s_axis_tready),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tready  (m_axis_tready),
        .stat_accepted  (stat_accepted),
        .stat_duplicate (stat_duplicate),
        .stat_error     (stat_error),
        .busy           (busy)
    );

    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: per-channel expected bit and last reply, plus stats.
    bit          m_exp_bit [NC];
    logic [31:0] m_last    [NC];
    int          m_acc, m_dup, m_err;

    task automatic model_reset();
        for (int i = 0; i < NC; i++) begin
            m_exp_bit[i] = 1'b0;
            m_last[i]    = 32'h0;
        end
        m_acc = 0;
        m_dup = 0;
        m_err = 0;
    endtask

    function automatic int sat16(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    // Stimulus buffer and capture queue
    logic [7:0] pkt_buf [0:127];
    int         pkt_len;
    logic [8:0] cap_q [$];
    logic [8:0] exp_buf [0:PS-1];
    int         exp_len;
    int         first_valid_cyc = -1;
    int         t_last_in = 0;
    bit         stall_mode = 0;
    bit         gap_mode = 0;

    // Output monitor and tready driver. A byte counts as transferred when
    // tvalid and tready are both high going into the next rising edge.
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    logic       prev_last  = 1'b0;

    always @(negedge aclk) begin
        m_axis_tready = stall_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
        if (aresetn && m_axis_tvalid) begin
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
            chk("s_ready_during_tx", s_axis_tready, 1'b0);
            if (prev_stall) begin
                chk("hold_tdata", m_axis_tdata, prev_data);
                chk("hold_tlast", m_axis_tlast, prev_last);
            end
            if (m_axis_tready) cap_q.push_back({m_axis_tlast, m_axis_tdata});
            prev_stall = ~m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_last  = m_axis_tlast;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic build_pkt(input bit b, input int ch, input logic [31:0] val, input int len);
        logic [31:0] v;
        v = val;
        pkt_len = len;
        for (int i = 0; i < len; i++) pkt_buf[i] = 8'($urandom);
        pkt_buf[0] = {b, 7'(ch)};
        for (int i = 1; i <= VS && i < len; i++) pkt_buf[i] = v[8*(VS-i) +: 8];
    endtask

    task automatic send_pkt();
        int t;
        for (int i = 0; i < pkt_len; i++) begin
            if (gap_mode && $urandom_range(0, 3) == 0) begin
                s_axis_tvalid = 1'b0;
                @(negedge aclk);
            end
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = pkt_buf[i];
            s_axis_tlast  = (i == pkt_len - 1);
            t = 0;
            while (!s_axis_tready && t < 500) begin
                @(negedge aclk);
                t++;
            end
            if (t >= 500) begin
                chk("input_ready_timeout", 1'b0, 1'b1);
                break;
            end
            if (i == pkt_len - 1) t_last_in = cyc;
            @(negedge aclk);
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic check_stats();
        chk("stat_accepted", stat_accepted, 64'(sat16(m_acc)));
        chk("stat_duplicate", stat_duplicate, 64'(sat16(m_dup)));
        chk("stat_error", stat_error, 64'(sat16(m_err)));
    endtask

    // Sends one packet and checks the reply (or its absence) against the model.
    task automatic run_pkt(input bit b, input int ch, input logic [31:0] val,
                           input int len, input bit chk_lat);
        logic [31:0] reply;
        int t;
        build_pkt(b, ch, val, len);
        cap_q.delete();
        first_valid_cyc = -1;
        send_pkt();

        exp_len = 0;
        if (len != PS || ch >= NC) begin
            m_err++;
        end else begin
            if (b == m_exp_bit[ch]) begin
                reply        = val + 32'd1;
                m_last[ch]   = reply;
                m_exp_bit[ch] = ~m_exp_bit[ch];
                m_acc++;
            end else begin
                reply = m_last[ch];
                m_dup++;
            end
            exp_len = PS;
            for (int i = 0; i < PS; i++) exp_buf[i] = {(i == PS - 1), 8'h00};
            exp_buf[0][7:0] = {b, 7'(ch)};
            for (int i = 1; i <= VS; i++) exp_buf[i][7:0] = reply[8*(VS-i) +: 8];
        end

        t = 0;
        while (cap_q.size() < exp_len && t < 3000) begin
            @(negedge aclk);
            t++;
        end
        if (t >= 3000) chk("output_timeout", 64'(cap_q.size()), 64'(exp_len));
        repeat (4) @(negedge aclk);

        chk("out_len", 64'(cap_q.size()), 64'(exp_len));
        if (cap_q.size() == exp_len) begin
            for (int i = 0; i < exp_len; i++) chk($sformatf("out_byte%0d", i), cap_q[i], exp_buf[i]);
        end
        if (chk_lat && exp_len > 0) chk("latency", 64'(first_valid_cyc - t_last_in), 64'd2);
        chk("busy_idle", busy, 1'b0);
        check_stats();
    endtask

    initial begin
        int t;
        model_reset();
        repeat (3) @(negedge aclk);
        chk("rst_s_tready", s_axis_tready, 1'b0);
        chk("rst_m_tvalid", m_axis_tvalid, 1'b0);
        chk("rst_m_tdata", m_axis_tdata, 8'h00);
        chk("rst_m_tlast", m_axis_tlast, 1'b0);
        chk("rst_busy", busy, 1'b0);
        check_stats();
        aresetn = 1'b1;
        @(negedge aclk);
        chk("idle_s_tready", s_axis_tready, 1'b1);

        // Directed cases
        run_pkt(1'b0, 0, 32'h0000_0005, PS, 1'b1);
        run_pkt(1'b0, 0, 32'h0000_0005, PS, 1'b1);
        run_pkt(1'b1, 0, 32'h0000_0010, PS, 1'b1);
        run_pkt(1'b0, 2, 32'hFFFF_FFFF, PS, 1'b1);
        run_pkt(1'b0, 1, 32'h0000_0033, PS, 1'b1);
        run_pkt(1'b0, 0, 32'h0000_0001, 11, 1'b0);
        run_pkt(1'b0, 0, 32'h0000_0001, 70, 1'b0);
        run_pkt(1'b0, 5, 32'h0000_0001, PS, 1'b0);
        run_pkt(1'b0, 0, 32'h0000_0001, 1, 1'b0);

        // Output back-pressure, then randomized traffic
        stall_mode = 1;
        run_pkt(1'b0, 0, 32'h0000_1234, PS, 1'b0);
        run_pkt(1'b0, 0, 32'h0000_1234, PS, 1'b0);
        for (int n = 0; n < 40; n++) begin
            int r, len;
            r = $urandom_range(0, 9);
            if (r == 0)      len = $urandom_range(1, PS - 1);
            else if (r == 1) len = $urandom_range(PS + 1, 80);
            else             len = PS;
            gap_mode   = ($urandom_range(0, 1) == 1);
            stall_mode = ($urandom_range(0, 3) != 0);
            run_pkt(1'(($urandom_range(0, 1))), $urandom_range(0, 5), 32'($urandom), len, 1'b0);
        end
        gap_mode   = 0;
        stall_mode = 0;

        // Reset during TX aborts the reply and clears all channel state
        build_pkt(1'b0, 0, 32'h0000_0099, PS);
        cap_q.delete();
        send_pkt();
        t = 0;
        while (cap_q.size() < 10 && t < 200) begin
            @(negedge aclk);
            t++;
        end
        chk("mid_tx_reached", 64'(cap_q.size() >= 10), 64'd1);
        #2 aresetn = 1'b0;
        #1;
        chk("arst_m_tvalid", m_axis_tvalid, 1'b0);
        chk("arst_m_tdata", m_axis_tdata, 8'h00);
        chk("arst_m_tlast", m_axis_tlast, 1'b0);
        chk("arst_s_tready", s_axis_tready, 1'b0);
        chk("arst_busy", busy, 1'b0);
        model_reset();
        check_stats();
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        cap_q.delete();
        run_pkt(1'b0, 0, 32'h0000_0007, PS, 1'b1);
        run_pkt(1'b1, 1, 32'h0000_0055, PS, 1'b1);
        run_pkt(1'b1, 0, 32'h0000_0020, PS, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
